loop_control: RTL

Program-flow controller for the Brainfuck core's front end. It owns the program counter and drives the fetch stage's enable/acknowledge. It consumes decoded opcodes to resolve `[` and `]` branches: a loop-return address stack handles backward jumps, and a nesting-depth counter handles forward skips. It sits between the fetch stage (which it feeds `pc` and `ack`) and the data-cell unit (which supplies the current-cell-zero flag).

---
 rtl/loop_control_if.sv | 18 +
 rtl/loop_control.sv | 107 ++++++++++
 2 files changed

// File: rtl/loop_control_if.sv
// loop_control_if: fetch, opcode and cell-status signals between loop_control and its neighbours
interface loop_control_if #(parameter int A_WIDTH = 12, parameter int D_WIDTH = 8);
  logic [A_WIDTH-1:0] pc;
  logic ack;
  logic op_valid;
  logic [D_WIDTH-1:0] op;
  logic [A_WIDTH-1:0] op_addr;
  logic op_ready;
  logic cell_valid;
  logic cell_zero;
  logic flush;
  logic halted;
  logic [1:0] error;
  modport master (output pc, ack, op_ready, flush, halted, error,
                  input op_valid, op, op_addr, cell_valid, cell_zero);
  modport slave (input pc, ack, op_ready, flush, halted, error,
                 output op_valid, op, op_addr, cell_valid, cell_zero);
endinterface

// File: rtl/loop_control.sv
// loop_control: program counter and [ ] branch resolution for the Brainfuck front end
module loop_control #(
  parameter int A_WIDTH = 12,
  parameter int D_WIDTH = 8,
  parameter int STACK_DEPTH = 16,
  parameter int NEST_WIDTH = 8
) (
  input logic clk,
  input logic reset,
  loop_control_if.master bus
);
  localparam int SP_W = $clog2(STACK_DEPTH) + 1;
  typedef enum logic [1:0] {RUN, SKIP, REDIR, HALT} state_t;
  state_t state_q, state_d;
  logic live_q;
  logic [A_WIDTH-1:0] pc_q, pc_d, ret;
  logic [SP_W-1:0] sp_q, sp_d;
  logic [SP_W-2:0] top;
  logic [NEST_WIDTH-1:0] depth_q, depth_d;
  logic halted_q, halted_d;
  logic [1:0] error_q, error_d;
  logic [A_WIDTH-1:0] stack_q [STACK_DEPTH];
  logic run, is_open, is_close, stall, ack, ready, push;
  // live_q holds fetch off for the first cycle after reset release
  always_comb begin
    run = live_q && state_q == RUN;
    is_open = bus.op_valid && bus.op == D_WIDTH'(8'h5B);
    is_close = bus.op_valid && bus.op == D_WIDTH'(8'h5D);
    stall = run && (is_open || is_close) && !bus.cell_valid;
    ack = (run && !stall) || state_q == SKIP;
    ready = ack || state_q == REDIR;
    ret = bus.op_addr + 1'b1;
    top = sp_q[SP_W-2:0] - 1'b1;
    state_d = state_q;
    pc_d = ack ? pc_q + 1'b1 : pc_q;
    sp_d = sp_q;
    depth_d = depth_q;
    halted_d = halted_q;
    error_d = error_q;
    push = 1'b0;
    if (state_q == REDIR) state_d = depth_q != '0 ? SKIP : RUN;
    if (state_q == SKIP && is_open) begin
      depth_d = depth_q + 1'b1;
      state_d = &depth_q ? HALT : SKIP;
      error_d = &depth_q ? 2'd3 : error_q;
    end
    if (state_q == SKIP && is_close) begin
      depth_d = depth_q - 1'b1;
      state_d = depth_q == NEST_WIDTH'(1) ? RUN : SKIP;
    end
    if (run && bus.op_valid && bus.op == '0) begin
      halted_d = 1'b1;
      state_d = HALT;
    end
    if (run && is_open && bus.cell_valid) begin
      if (bus.cell_zero) begin
        depth_d = NEST_WIDTH'(1);
        pc_d = ret;
        state_d = REDIR;
      end else if (sp_q == SP_W'(STACK_DEPTH)) begin
        error_d = 2'd1;
        state_d = HALT;
      end else begin
        push = 1'b1;
        sp_d = sp_q + 1'b1;
      end
    end
    if (run && is_close && bus.cell_valid) begin
      if (sp_q == '0) begin
        error_d = 2'd2;
        state_d = HALT;
      end else if (bus.cell_zero) begin
        sp_d = sp_q - 1'b1;
      end else begin
        pc_d = stack_q[top];
        state_d = REDIR;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      live_q <= 1'b0;
      pc_q <= '0;
      sp_q <= '0;
      depth_q <= '0;
      halted_q <= 1'b0;
      error_q <= '0;
    end else begin
      state_q <= state_d;
      live_q <= 1'b1;
      pc_q <= pc_d;
      sp_q <= sp_d;
      depth_q <= depth_d;
      halted_q <= halted_d;
      error_q <= error_d;
    end
  end
  always_ff @(posedge clk)
    if (push) stack_q[sp_q[SP_W-2:0]] <= ret;
  assign bus.pc = pc_q;
  assign bus.ack = ack;
  assign bus.op_ready = ready;
  assign bus.flush = state_q == REDIR;
  assign bus.halted = halted_q;
  assign bus.error = error_q;
endmodule
